// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_arb_pkg
// Brief    : Shared types and default widths for the two-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    // Default widths of the shared main memory
    localparam int unsigned ADDR_W_DEFAULT = 23;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Requester index: 0 = instruction fetch, 1 = load/store
    typedef logic req_idx_t;

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/arb_pick2.sv
`default_nettype none
// ============================================================================
// Module   : arb_pick2
// Brief    : Combinational two-way request picker. A lone request always
//            wins; on a tie, round-robin mode picks the requester that was
//            not granted last, fixed mode always picks requester 1.
// Revision : 1.0 - initial release
// ============================================================================
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   last_i,
    input  logic       rr_mode_i,
    output req_idx_t   grant_o,
    output logic       valid_o
);

    // Resolve the request vector into a single winner
    always_comb begin
        valid_o = |req_i;
        grant_o = 1'b0;
        case (req_i)
            2'b01:   grant_o = 1'b0;
            2'b10:   grant_o = 1'b1;
            2'b11:   grant_o = rr_mode_i ? ~last_i : 1'b1;
            default: grant_o = 1'b0;
        endcase
    end

endmodule : arb_pick2
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Brief    : Serialises instruction-fetch (0) and load/store (1) accesses
//            onto a single-port memory via IDLE -> ACCESS -> RESP, returning
//            read data and a one-cycle Ack to the winner.
//            Optional macro RAM_ARB_RR_EN: round-robin tie-break with a
//            last-grant register. Without it, requester 1 wins every tie.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWE,
    output logic              MemRE,
    input  logic [DATA_W-1:0] MemReadData
);

    arb_state_e        state_q,  state_d;
    req_idx_t          winner_q, winner_d;
    logic              we_q,     we_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    req_idx_t          pick_grant;
    logic              pick_valid;
    req_idx_t          last_grant;
    logic              rr_mode;

    // Requests are only looked at in IDLE; later changes are ignored
    arb_pick2 u_pick (
        .req_i     ({Req1, Req0}),
        .last_i    (last_grant),
        .rr_mode_i (rr_mode),
        .grant_o   (pick_grant),
        .valid_o   (pick_valid)
    );

`ifdef RAM_ARB_RR_EN
    req_idx_t last_q, last_d;

    // Remember who was granted most recently; reset favours requester 0
    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && pick_valid) begin
            last_d = pick_grant;
        end
    end

    // Last-grant register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant = last_q;
    assign rr_mode    = 1'b1;
`else
    // Fixed priority: tie always resolves to requester 1
    assign last_grant = 1'b1;
    assign rr_mode    = 1'b0;
`endif

    // Next-state and datapath capture for the access sequencer
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_grant;
                    we_d     = pick_grant ? We1    : We0;
                    addr_d   = pick_grant ? Addr1  : Addr0;
                    wdata_d  = pick_grant ? WData1 : WData0;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // Read data is captured at the edge that leaves ACCESS
                if (!we_q) begin
                    if (winner_q) begin
                        rdata1_d = MemReadData;
                    end else begin
                        rdata0_d = MemReadData;
                    end
                end
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and datapath registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            winner_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Outputs decode registered state only; reset clears enables at once
    assign MemAddress   = addr_q;
    assign MemWriteData = wdata_q;
    assign MemWE        = (state_q == ACCESS) &&  we_q;
    assign MemRE        = (state_q == ACCESS) && !we_q;
    assign Ack0         = (state_q == RESP)   && (winner_q == 1'b0);
    assign Ack1         = (state_q == RESP)   && (winner_q == 1'b1);
    assign RData0       = rdata0_q;
    assign RData1       = rdata1_q;

endmodule : ram_arbiter
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Brief    : Directed self-checking bench for ram_arbiter with a small
//            behavioural memory (combinational read, posedge write).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req0, Req1, We0, We1;
    logic [22:0] Addr0, Addr1;
    logic [31:0] WData0, WData1;
    logic        Ack0, Ack1;
    logic [31:0] RData0, RData1;
    logic [22:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWE, MemRE;
    logic [31:0] MemReadData;

    logic [31:0] mem [0:4095];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_both = 0;

    ram_arbiter #(.ADDR_W(23), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Req0         (Req0),
        .Req1         (Req1),
        .We0          (We0),
        .We1          (We1),
        .Addr0        (Addr0),
        .Addr1        (Addr1),
        .WData0       (WData0),
        .WData1       (WData1),
        .Ack0         (Ack0),
        .Ack1         (Ack1),
        .RData0       (RData0),
        .RData1       (RData1),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWE        (MemWE),
        .MemRE        (MemRE),
        .MemReadData  (MemReadData)
    );

    always #5 Clk = ~Clk;

    // Memory model: preset contents C0DE0000+index, write on posedge
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
        forever begin
            @(posedge Clk);
            if (MemWE) mem[MemAddress[11:0]] <= MemWriteData;
        end
    end
    assign MemReadData = mem[MemAddress[11:0]];

    // Enables must never be active together
    always @(negedge Clk) if (MemWE && MemRE) n_both++;

    task automatic cycle();
        @(posedge Clk);
        #1;
    endtask

    // Drive one request from IDLE and wait (bounded) for its Ack
    task automatic issue(input int idx, input logic we, input logic [22:0] a,
                         input logic [31:0] d, output bit got, output int lat,
                         output logic [31:0] rd, output bit other);
        got = 0; lat = 0; rd = '0; other = 0;
        if (idx == 0) begin Req0 = 1; We0 = we; Addr0 = a; WData0 = d; end
        else          begin Req1 = 1; We1 = we; Addr1 = a; WData1 = d; end
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if ((idx == 0) ? Ack1 : Ack0) other = 1;
            if ((idx == 0) ? Ack0 : Ack1) begin
                got = 1; lat = i; rd = (idx == 0) ? RData0 : RData1;
                break;
            end
        end
        Req0 = 0; Req1 = 0;
        cycle();
    endtask

    task automatic test_reset();
        Rst_n = 0; Req0 = 1; We0 = 0; Addr0 = 23'd5; WData0 = '0;
        Req1 = 0; We1 = 0; Addr1 = '0; WData1 = '0;
        repeat (2) cycle();
        n_cmp++;
        if ({Ack0, Ack1, MemWE, MemRE} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 0000", {Ack0, Ack1, MemWE, MemRE});
        end
        n_cmp++;
        if ({MemAddress, MemWriteData, RData0, RData1} !== '0) begin
            n_bad++; $display("FAIL reset_data: addr=%h wd=%h rd0=%h rd1=%h want 0",
                              MemAddress, MemWriteData, RData0, RData1);
        end
        Rst_n = 1;
        cycle();
        n_cmp++;
        if ({MemRE, MemWE} !== 2'b10 || MemAddress !== 23'd5) begin
            n_bad++; $display("FAIL reset_c1: re=%b we=%b addr=%0d want re=1 we=0 addr=5", MemRE, MemWE, MemAddress);
        end
        cycle();
        n_cmp++;
        if ({Ack0, Ack1} !== 2'b10 || RData0 !== 32'hC0DE_0005) begin
            n_bad++; $display("FAIL reset_c2: ack0=%b ack1=%b rd0=%h want 1 0 c0de0005", Ack0, Ack1, RData0);
        end
        Req0 = 0;
        cycle();
    endtask

    task automatic test_write_read();
        bit got, other; int lat; logic [31:0] rd;
        issue(0, 1'b1, 23'd1024, 32'hDEADBEEF, got, lat, rd, other);
        n_cmp++;
        if (!got || lat != 2 || other) begin
            n_bad++; $display("FAIL wr_ack: got=%0d lat=%0d other=%0d want 1 2 0", got, lat, other);
        end
        n_cmp++;
        if (rd !== 32'hC0DE_0005) begin
            n_bad++; $display("FAIL wr_rdata_hold: got %h want c0de0005", rd);
        end
        n_cmp++;
        if (mem[1024] !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL wr_mem: got %h want deadbeef", mem[1024]);
        end
        issue(0, 1'b0, 23'd1024, 32'h0, got, lat, rd, other);
        n_cmp++;
        if (!got || lat != 2 || other || rd !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL rd_back: got=%0d lat=%0d other=%0d rd=%h want 1 2 0 deadbeef", got, lat, other, rd);
        end
        n_cmp++;
        if (RData1 !== 32'h0) begin
            n_bad++; $display("FAIL rd_other_hold: RData1=%h want 0", RData1);
        end
    endtask

    task automatic test_tie();
        logic [1:0] exp;
        Rst_n = 0; cycle(); Rst_n = 1;
        Req0 = 1; We0 = 0; Addr0 = 23'd1030;
        Req1 = 1; We1 = 0; Addr1 = 23'd1031;
        for (int c = 1; c <= 14; c++) begin
            cycle();
            exp = 2'b00;
            if (c == 14) exp = 2'b01;
            else if (c == 2 || c == 5 || c == 8 || c == 11) begin
`ifdef RAM_ARB_RR_EN
                exp = (c == 2 || c == 8) ? 2'b01 : 2'b10;
`else
                exp = 2'b10;
`endif
            end
            n_cmp++;
            if ({Ack1, Ack0} !== exp) begin
                n_bad++; $display("FAIL tie_ack c%0d: ack1ack0=%b want %b", c, {Ack1, Ack0}, exp);
            end
            if (exp == 2'b01 && RData0 !== 32'hC0DE_0406) begin
                n_cmp++; n_bad++; $display("FAIL tie_rd0 c%0d: got %h want c0de0406", c, RData0);
            end
            if (exp == 2'b10 && RData1 !== 32'hC0DE_0407) begin
                n_cmp++; n_bad++; $display("FAIL tie_rd1 c%0d: got %h want c0de0407", c, RData1);
            end
            if (c == 11) Req1 = 0;
        end
        Req0 = 0;
        cycle();
    endtask

    task automatic test_reset_mid_write();
        bit got, other; int lat; logic [31:0] rd;
        Req1 = 1; We1 = 1; Addr1 = 23'd1088; WData1 = 32'h5;
        cycle();
        n_cmp++;
        if (MemWE !== 1'b1) begin
            n_bad++; $display("FAIL midrst_we_on: MemWE=%b want 1", MemWE);
        end
        #2 Rst_n = 0;
        #1;
        n_cmp++;
        if (MemWE !== 1'b0) begin
            n_bad++; $display("FAIL midrst_we_async: MemWE=%b want 0", MemWE);
        end
        Req1 = 0;
        cycle();
        n_cmp++;
        if (Ack1 !== 1'b0 || mem[1088] !== 32'hC0DE_0440) begin
            n_bad++; $display("FAIL midrst_nocommit: ack1=%b mem=%h want 0 c0de0440", Ack1, mem[1088]);
        end
        Rst_n = 1;
        cycle();
        issue(1, 1'b0, 23'd1088, 32'h0, got, lat, rd, other);
        n_cmp++;
        if (!got || lat != 2 || rd !== 32'hC0DE_0440) begin
            n_bad++; $display("FAIL midrst_readback: got=%0d lat=%0d rd=%h want 1 2 c0de0440", got, lat, rd);
        end
    endtask

    task automatic test_addr_change();
        Req1 = 1; We1 = 0; Addr1 = 23'd1089;
        cycle();
        n_cmp++;
        if (MemAddress !== 23'd1089 || MemRE !== 1'b1) begin
            n_bad++; $display("FAIL achg_access: addr=%0d re=%b want 1089 1", MemAddress, MemRE);
        end
        Addr1 = 23'd1090;
        cycle();
        n_cmp++;
        if (Ack1 !== 1'b1 || RData1 !== 32'hC0DE_0441) begin
            n_bad++; $display("FAIL achg_data: ack1=%b rd1=%h want 1 c0de0441", Ack1, RData1);
        end
        Req1 = 0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_tie();
        test_reset_mid_write();
        test_addr_change();
        n_cmp++;
        if (n_both != 0) begin
            n_bad++; $display("FAIL we_re_exclusive: both-high cycles=%0d want 0", n_both);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ram_arbiter
`default_nettype wire
